// File: rtl/led_seq_pkg.sv
// ----------------------------------------------------------------------------
// led_seq_pkg : register map, field positions, encodings and step function for
//               the LED sequencer.   Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none
package led_seq_pkg;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_PERIOD  = 3'd1;
  localparam logic [2:0] ADDR_PATTERN = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_ONESHOT  = 3;
  localparam int CTRL_IRQ_EN   = 4;
  localparam int CTRL_W        = 5;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_CNT   = 2'b10;
  localparam logic [1:0] MODE_BLINK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] PERIOD_RST = 8'hFF;

  function automatic logic [7:0] next_pattern(input logic [1:0] mode,
                                              input logic [7:0] w,
                                              input logic [7:0] pat);
    case (mode)
      MODE_ROT:   return {w[6:0], w[7]};
      MODE_CNT:   return w + 8'd1;
      MODE_BLINK: return w ^ pat;
      default:    return w;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
// ----------------------------------------------------------------------------
// led_tick_gen : prescaler plus period counter producing the LED step tick.
//                Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none
module led_tick_gen #(
  parameter int PRESCALE   = 1000,
  parameter int PRESCALE_W = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_run,
  input  logic [7:0] i_period,
  output logic       o_tick
);

  localparam logic [PRESCALE_W-1:0] c_pre_last = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] r_pre;
  logic [7:0]            r_pcnt;
  logic                  w_pulse;

  assign w_pulse = i_run && (r_pre == c_pre_last);
  // Compare against the live period so a lowered value fires on the next pulse.
  assign o_tick  = w_pulse && (r_pcnt >= i_period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_pcnt <= '0;
    end else if (!i_run) begin
      r_pre  <= '0;
      r_pcnt <= '0;
    end else begin
      r_pre <= w_pulse ? '0 : r_pre + PRESCALE_W'(1);
      if (o_tick)
        r_pcnt <= '0;
      else if (w_pulse)
        r_pcnt <= r_pcnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
// ----------------------------------------------------------------------------
// led_seq_ctrl : APB3 slave that steps the LEDCON port on a prescaled tick.
//                Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none
module led_seq_ctrl #(
  parameter int PRESCALE   = 1000,
  parameter int PRESCALE_W = 10
) (
  input  logic       PCLK,
  input  logic       PRESERN,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [4:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic [7:0] LEDCON,
  output logic       IRQ,
  output logic [4:0] TPS
);
  import led_seq_pkg::*;

  logic [2:0]        w_reg;
  logic              w_acc, w_mapped, w_wr;
  logic              w_wr_ctrl, w_wr_period, w_wr_pattern, w_wr_status;
  logic              w_unused_addr;
  state_e            r_state, w_next;
  logic [CTRL_W-1:0] r_ctrl;
  logic [7:0]        r_period, r_pattern, r_w;
  logic              r_done, r_irq;
  logic [2:0]        r_step;
  logic              w_run, w_tick, w_do_step, w_finish, w_enter_run;

  assign w_reg         = PADDR[4:2];
  assign w_unused_addr = ^PADDR[1:0];
  assign w_mapped      = !PADDR[4];
  assign w_acc         = PSEL && PENABLE;
  assign w_wr          = w_acc && PWRITE && w_mapped;
  assign w_wr_ctrl     = w_wr && (w_reg == ADDR_CTRL);
  assign w_wr_period   = w_wr && (w_reg == ADDR_PERIOD);
  assign w_wr_pattern  = w_wr && (w_reg == ADDR_PATTERN);
  assign w_wr_status   = w_wr && (w_reg == ADDR_STATUS);

  assign PREADY  = 1'b1;
  assign PSLVERR = w_acc && !w_mapped;
  assign LEDCON  = r_w;
  assign IRQ     = r_irq;
  assign TPS     = {r_irq, r_state, w_tick, PCLK};
  assign w_run   = (r_state == ST_RUN);

  led_tick_gen #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_tick (
    .clk      (PCLK),
    .rst_n    (PRESERN),
    .i_run    (w_run),
    .i_period (r_period),
    .o_tick   (w_tick)
  );

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (w_reg)
        ADDR_CTRL:    PRDATA = {3'b000, r_ctrl};
        ADDR_PERIOD:  PRDATA = r_period;
        ADDR_PATTERN: PRDATA = r_pattern;
        ADDR_STATUS:  PRDATA = {6'b0, r_done, w_run};
        default:      PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // A disabling CTRL write outranks a coincident tick: no step is applied.
  always_comb begin
    w_next    = r_state;
    w_do_step = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      ST_IDLE: if (w_wr_ctrl && PWDATA[CTRL_EN]) w_next = ST_RUN;
      ST_RUN: begin
        if (w_wr_ctrl && !PWDATA[CTRL_EN]) begin
          w_next = ST_IDLE;
        end else if (w_tick) begin
          w_do_step = 1'b1;
          if (r_ctrl[CTRL_ONESHOT] && (r_step == 3'd7)) begin
            w_finish = 1'b1;
            w_next   = ST_DONE;
          end
        end
      end
      ST_DONE: if (w_wr_ctrl) w_next = PWDATA[CTRL_EN] ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_enter_run = (w_next == ST_RUN) && (r_state != ST_RUN);

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_ctrl    <= '0;
      r_period  <= PERIOD_RST;
      r_pattern <= '0;
      r_done    <= 1'b0;
      r_w       <= '0;
      r_step    <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr_ctrl)    r_ctrl <= PWDATA[CTRL_W-1:0];
      if (w_finish)     r_ctrl[CTRL_EN] <= 1'b0;
      if (w_wr_period)  r_period <= PWDATA;
      if (w_wr_pattern) r_pattern <= PWDATA;

      if (w_finish)
        r_done <= 1'b1;
      else if (w_wr_status && PWDATA[1])
        r_done <= 1'b0;

      if ((r_state == ST_IDLE) || w_enter_run)
        r_w <= r_pattern;
      else if (w_do_step)
        r_w <= next_pattern(r_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB], r_w, r_pattern);

      if (w_enter_run)
        r_step <= '0;
      else if (w_do_step)
        r_step <= r_step + 3'd1;

      r_irq <= r_done && r_ctrl[CTRL_IRQ_EN];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_led_seq_ctrl : scoreboard bench for led_seq_ctrl with PRESCALE = 4.
//                   Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none
module tb_led_seq_ctrl;

  localparam int PS = 4;

  logic       PCLK = 1'b0, PRESERN = 1'b0;
  logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [4:0] PADDR = '0;
  logic [7:0] PWDATA = '0;
  logic [7:0] PRDATA, LEDCON;
  logic       PREADY, PSLVERR, IRQ;
  logic [4:0] TPS;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct packed {logic [7:0] val; logic [31:0] c;} ev_t;
  typedef struct packed {bit rd; logic [7:0] data; bit err;} acc_t;
  ev_t  q_led[$];
  ev_t  q_irq[$];
  acc_t q_acc[$];

  logic [7:0] m_led = 8'h00, m_ctrl = 8'h00, m_period = 8'hFF, m_pattern = 8'h00;
  bit         m_done = 1'b0, m_irq = 1'b0;
  logic [7:0] last_led = 8'h00;
  logic       last_irq = 1'b0;

  led_seq_ctrl #(.PRESCALE(PS), .PRESCALE_W(2)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .LEDCON(LEDCON), .IRQ(IRQ), .TPS(TPS)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference step rule written as plain arithmetic on the LED value.
  function automatic logic [7:0] model_step(input logic [1:0] mode, input logic [7:0] w,
                                            input logic [7:0] p);
    int x;
    x = int'(w);
    case (mode)
      2'd1:    x = (x * 2 + x / 128) % 256;
      2'd2:    x = (x + 1) % 256;
      2'd3:    x = x ^ int'(p);
      default: x = x;
    endcase
    return x[7:0];
  endfunction

  function automatic void exp_led(input logic [7:0] v, input int c);
    ev_t e;
    if (v != m_led) begin
      e.val = v; e.c = c; q_led.push_back(e); m_led = v;
    end
  endfunction

  function automatic void exp_irq(input bit v, input int c);
    ev_t e;
    if (v != m_irq) begin
      e.val = {7'b0, v}; e.c = c; q_irq.push_back(e); m_irq = v;
    end
  endfunction

  // Monitors: every observed output change or APB access phase pops one expectation.
  always @(negedge PCLK) begin
    if (LEDCON !== last_led) begin
      if (q_led.size() == 0) check("led_unexpected_change", q_led.size(), 1);
      else begin
        ev_t e;
        e = q_led.pop_front();
        check("led_value", LEDCON, e.val);
        check("led_cycle", cyc, e.c);
      end
      last_led = LEDCON;
    end
  end

  always @(negedge PCLK) begin
    if (IRQ !== last_irq) begin
      if (q_irq.size() == 0) check("irq_unexpected_change", q_irq.size(), 1);
      else begin
        ev_t e;
        e = q_irq.pop_front();
        check("irq_value", IRQ, e.val[0]);
        check("irq_cycle", cyc, e.c);
      end
      last_irq = IRQ;
    end
  end

  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      if (q_acc.size() == 0) check("apb_unexpected_access", q_acc.size(), 1);
      else begin
        acc_t a;
        a = q_acc.pop_front();
        check("pready_pslverr", {PREADY, PSLVERR}, {1'b1, a.err});
        if (a.rd) check("prdata", PRDATA, a.data);
      end
    end
  end

  // Called just after a falling edge; the write commits cyc+2 rising edges later.
  task automatic apb(input bit wr, input logic [4:0] a, input logic [7:0] d,
                     input logic [7:0] exp, input bit err);
    acc_t t;
    t.rd = !wr; t.data = exp; t.err = err;
    q_acc.push_back(t);
    #1;
    PSEL = 1'b1; PWRITE = wr; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge PCLK); #1 PENABLE = 1'b1;
    @(negedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    apb(1'b1, a, d, 8'h00, a[4]);
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp);
    apb(1'b0, a, 8'h00, exp, a[4]);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge PCLK);
  endtask

  // Enable a run, let k ticks elapse, then disable d cycles after the k-th tick slot.
  task automatic run_seq(input logic [7:0] pat, input logic [1:0] mode, input logic [7:0] per,
                         input bit os, input bit ie, input int k, input int d);
    int T, c, C, cs, effk, steps;
    logic [7:0] w, ctl;
    T = (int'(per) + 1) * PS;
    c = cyc + 2; wr(5'h0C, 8'h02); m_done = 1'b0; exp_irq(1'b0, c + 1);
    wr(5'h04, per); m_period = per;
    c = cyc + 2; wr(5'h08, pat); m_pattern = pat; exp_led(pat, c + 1);
    ctl = {3'b000, ie, os, mode, 1'b1};
    C = cyc + 2; wr(5'h00, ctl); m_ctrl = ctl;
    effk  = (d == 0) ? k - 1 : k;
    steps = (os && effk > 8) ? 8 : effk;
    w = pat;
    for (int i = 1; i <= steps; i++) begin
      w = model_step(mode, w, pat);
      exp_led(w, C + i * T);
    end
    if (os && effk >= 8) begin
      m_done = 1'b1;
      m_ctrl[0] = 1'b0;
      exp_irq(ie, C + 8 * T + 1);
      if (k * T + d >= 8 * T + 10) begin
        wait_until(C + 8 * T + 1);
        rd(5'h0C, 8'h02);
        rd(5'h00, m_ctrl);
      end
    end
    cs = C + k * T + d;
    wait_until(cs - 2);
    ctl = {3'b000, ie, os, mode, 1'b0};
    wr(5'h00, ctl); m_ctrl = ctl;
    exp_led(pat, cs + 1);
    rd(5'h0C, {6'b0, m_done, 1'b0});
    rd(5'h00, m_ctrl);
    rd(5'h08, m_pattern);
    rd(5'h04, m_period);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, C;
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b1;
    @(negedge PCLK);
    check("reset_ledcon", LEDCON, 8'h00);
    check("reset_irq", IRQ, 1'b0);
    check("reset_pslverr", PSLVERR, 1'b0);
    rd(5'h00, 8'h00);
    rd(5'h04, 8'hFF);
    rd(5'h08, 8'h00);
    rd(5'h0C, 8'h00);

    run_seq(8'h81, 2'd1, 8'd1, 1'b0, 1'b0, 3, 4);   // rotate, 8-cycle step
    run_seq(8'hFE, 2'd2, 8'd0, 1'b1, 1'b1, 12, 1);  // counter wrap, one-shot, irq
    run_seq(8'h55, 2'd3, 8'd0, 1'b0, 1'b0, 2, 0);   // disable on a tick edge

    wr(5'h14, 8'hA5);
    rd(5'h14, 8'h00);
    wr(5'h1C, 8'h3C);
    rd(5'h00, m_ctrl);
    rd(5'h04, m_period);
    rd(5'h08, m_pattern);

    for (int it = 0; it < 16; it++) begin
      logic [7:0] p, per;
      logic [1:0] md;
      bit os, ie;
      int k, d;
      p   = 8'($urandom);
      md  = 2'($urandom_range(0, 3));
      per = 8'($urandom_range(0, 3));
      os  = 1'($urandom_range(0, 1));
      ie  = 1'($urandom_range(0, 1));
      k   = $urandom_range(1, 11);
      d   = $urandom_range(0, (int'(per) + 1) * PS - 1);
      run_seq(p, md, per, os, ie, k, d);
    end

    // Asynchronous reset in the middle of a rotate run.
    c = cyc + 2; wr(5'h08, 8'h81); m_pattern = 8'h81; exp_led(8'h81, c + 1);
    wr(5'h04, 8'h00); m_period = 8'h00;
    C = cyc + 2; wr(5'h00, 8'h03); m_ctrl = 8'h03;
    exp_led(8'h03, C + PS);
    exp_led(8'h06, C + 2 * PS);
    wait_until(C + 2 * PS + 1);
    @(posedge PCLK);
    #2;
    exp_led(8'h00, cyc);
    exp_irq(1'b0, cyc);
    PRESERN = 1'b0;
    #1;
    check("async_rst_ledcon", LEDCON, 8'h00);
    check("async_rst_irq", IRQ, 1'b0);
    check("async_rst_state", TPS[3:2], 2'b00);
    m_ctrl = 8'h00; m_period = 8'hFF; m_pattern = 8'h00; m_done = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b1;
    rd(5'h04, 8'hFF);
    rd(5'h00, 8'h00);
    rd(5'h0C, 8'h00);

    wait_until(cyc + 4);
    check("led_events_left", q_led.size(), 0);
    check("irq_events_left", q_irq.size(), 0);
    check("apb_accesses_left", q_acc.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- APB3 slave controller that sequences the 8-bit LEDCON port on the Fabric APB bus, one PSEL slot.
- Software programs a mode, a step period and a seed pattern, then enables the block.
- The block steps LEDCON autonomously on a prescaled tick, with optional one-shot completion and interrupt.

Parameters:
PRESCALE, 1000, PCLK cycles per prescaler pulse (>=2)
PRESCALE_W, 10, prescaler counter width (must hold PRESCALE-1)

Ports:
PCLK  in  1  system clock, all logic on rising edge
PRESERN  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  APB direction, 1 = write
PADDR  in  5  byte address; PADDR[4:2] selects the register
PWDATA  in  8  write data
PRDATA  out  8  read data
PREADY  out  1  always 1, no wait states
PSLVERR  out  1  error on access to an unmapped address
LEDCON  out  8  registered LED drive
IRQ  out  1  level interrupt
TPS  out  5  test points: {IRQ, state[1:0], tick, PCLK}

Behaviour:
- Reset: one clock, async active-low reset (PCLK / PRESERN). Asserting PRESERN low clears all of the following, immediately and including mid-run:
  - CTRL = 0, PERIOD = 8'hFF, PATTERN = 0, DONE = 0.
  - Working register W = 0, prescaler = 0, period counter = 0, step counter = 0.
  - State = IDLE; LEDCON = 0, IRQ = 0, PRDATA = 0.
- Register map:
  - 0x00 CTRL: [0] EN, [2:1] MODE, [3] ONESHOT, [4] IRQ_EN; [7:5] read 0.
  - 0x04 PERIOD.
  - 0x08 PATTERN.
  - 0x0C STATUS: [0] RUNNING, [1] DONE; a write with bit1 = 1 clears DONE.
  - 0x10-0x1C are unmapped.
- APB write: commits on the edge where PSEL & PENABLE & PWRITE.
- APB read: PRDATA is combinational from PADDR while PSEL & !PWRITE, else 0.
- PSLVERR: asserted only when PSEL & PENABLE and the address is unmapped. Unmapped writes are ignored; unmapped reads return 0.
- LEDCON = W, registered.
- Tick generator:
  - The prescaler counts 0..PRESCALE-1 and pulses at the terminal count.
  - The period counter advances on each pulse. tick = pulse & (pcnt >= PERIOD), and pcnt clears on tick.
  - The first tick arrives (PERIOD+1)*PRESCALE cycles after entering RUN.
  - Both counters hold at 0 outside RUN.
  - A PERIOD write during RUN takes effect at the next compare. If pcnt already exceeds the new value, tick fires on the next pulse.
- FSM, state IDLE:
  - W <= PATTERN every cycle, so LEDCON = PATTERN one cycle after a PATTERN write.
  - A CTRL write with EN = 1 goes to RUN and clears the counters and the step counter.
- FSM, state RUN, on each tick:
  - W steps by MODE: 00 hold; 01 rotate-left {W[6:0],W[7]}; 10 W+1 mod 256 (FF wraps to 00); 11 W ^ PATTERN, using live PATTERN.
  - The 3-bit step counter increments on each tick.
  - If ONESHOT and step counter == 7 at the tick: the step is applied, then go to DONE, set DONE, and clear CTRL.EN in hardware.
  - A CTRL write with EN = 0 goes to IDLE; LEDCON returns to PATTERN the next cycle.
  - A CTRL write with EN = 1 while in RUN does not restart; MODE and ONESHOT changes apply from the next tick.
  - A PATTERN write changes only PATTERN; W is unaffected, except through mode 11.
- FSM, state DONE:
  - W holds its last value.
  - A CTRL write with EN = 1 goes to RUN (reload from PATTERN, clear counters).
  - A CTRL write with EN = 0 goes to IDLE.
- Simultaneous events:
  - EN = 0 write and tick on the same edge: go to IDLE, no step.
  - STATUS clear and DONE set on the same edge: set wins.
- STATUS.RUNNING = (state == RUN).
- IRQ = DONE & IRQ_EN, registered.

Decomposition:
- Package led_seq_pkg holds:
  - Register offsets: ADDR_CTRL, ADDR_PERIOD, ADDR_PATTERN, ADDR_STATUS.
  - CTRL bit indices.
  - MODE encodings: MODE_HOLD, MODE_ROT, MODE_CNT, MODE_BLINK.
  - State encoding: ST_IDLE = 0, ST_RUN = 1, ST_DONE = 2.
  - PERIOD reset value.
- One sub-module, led_tick_gen:
  - Contains the prescaler and period counter.
  - Inputs: run, period[7:0]. Output: tick.
  - Parameterised by PRESCALE and PRESCALE_W.

Test Plan (PRESCALE = 4):
1. Release reset, read all four registers -> 0x00, 0xFF, 0x00, 0x00. LEDCON = 0, IRQ = 0, PSLVERR = 0.
2. PATTERN = 0x81, PERIOD = 1, CTRL = 0x03 (EN, rotate) -> first tick at 8 cycles after entry. LEDCON sequence 0x81, 0x03, 0x06, 0x0C; 8 PCLK between changes.
3. PATTERN = 0xFE, PERIOD = 0, CTRL = 0x1D (EN, count, ONESHOT, IRQ_EN) -> LEDCON goes 0xFF then 0x00 (wrap) … 0x06 after 8 ticks. STATUS = 0x02, IRQ = 1, CTRL reads 0x1C. Writing STATUS = 0x02 clears IRQ next cycle.
4. Blink, PATTERN = 0x55, running; at a tick edge write CTRL = 0x00 -> no step applied, state IDLE, LEDCON = 0x55 next cycle, STATUS = 0x00.
5. Write and read at 0x14 -> PSLVERR = 1 on both access phases; registers unchanged; PRDATA = 0.
6. Assert PRESERN low mid-RUN, asynchronously between edges -> LEDCON, IRQ and TPS state bits go to 0 immediately. After release, a read returns PERIOD = 0xFF.
